// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor (diff = a - b), LSB first,
// one bit per clock, using a single full-adder cell computing a + ~b + 1.
// Handshake is start/busy/done; results are held until the next done.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN adds an `add` input that
// turns the same datapath into a serial adder (diff = a + b).
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic         add,
`endif
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         overflow,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sa, sb, sr;
    logic [CW-1:0] cnt;
    logic          c;
    logic          op_add;

    logic          accept;
    logic          b_bit;
    logic          s;
    logic          c_nxt;
    logic          last;

`ifndef SERIAL_SUB_ADD_MODE_EN
    // Without the add feature the datapath is permanently a subtractor.
    assign op_add = 1'b0;
`endif

    // A new request is taken whenever the engine is not mid-operation;
    // accepting in DONE gives back-to-back operation with no idle gap.
    assign accept = start && ((state == IDLE) || (state == DONE));

    // One full-adder cell. In subtract mode the subtrahend bit is inverted
    // and the carry starts at 1 (two's-complement negate).
    assign b_bit  = op_add ? sb[0] : ~sb[0];
    assign s      = sa[0] ^ b_bit ^ c;
    assign c_nxt  = (sa[0] & b_bit) | (sa[0] & c) | (b_bit & c);
    assign last   = (cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result shift registers, bit counter and carry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            cnt <= '0;
            c   <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_add <= 1'b0;
`endif
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            cnt <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_add <= add;
            c      <= ~add;
`else
            c      <= 1'b1;
`endif
        end else if (state == RUN) begin
            c   <= c_nxt;
            sr  <= {s, sr[N-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers: loaded on the edge that computes the final (sign)
    // bit, so the full result is taken from the shifter input, not sr.
    // Sign-bit overflow: operands (after optional inversion) agree in sign
    // but the result sign differs; this single form covers both modes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if ((state == RUN) && last) begin
            diff     <= {s, sr[N-1:1]};
            borrow   <= op_add ? c_nxt : ~c_nxt;
            overflow <= (sa[0] == b_bit) && (s != sa[0]);
        end
    end

endmodule
